// File: rtl/dec_mux_add_pkg.sv
// Shared definitions for the decoder/mux/full-adder response checker:
// stim field layout, FSM encoding, MISR seed and MISR step.
package dec_mux_add_pkg;

    localparam int unsigned FIELD_W  = 2;
    localparam int unsigned SEL1_LSB = 0;
    localparam int unsigned EN_BIT   = 2;
    localparam int unsigned A_LSB    = 3;
    localparam int unsigned B_LSB    = 5;
    localparam int unsigned C_LSB    = 7;
    localparam int unsigned D_LSB    = 9;
    localparam int unsigned SEL2_LSB = 11;
    localparam int unsigned X_BIT    = 13;
    localparam int unsigned Y_BIT    = 14;
    localparam int unsigned CI_BIT   = 15;

    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // resp packs {Co, S, muxout[1:0], decout[3:0]}
    function automatic logic [15:0] misr_next(input logic [15:0] sig,
                                              input logic [7:0]  resp,
                                              input logic [15:0] poly);
        return {sig[14:0], 1'b0} ^ (sig[15] ? poly : 16'h0000) ^ {8'h00, resp};
    endfunction

endpackage

// File: rtl/dec_mux_add_model.sv
// Golden combinational model: 2-to-4 decoder with enable, 4:1 mux of
// 2-bit operands, and a full adder, all driven from one stim word.
module dec_mux_add_model
    import dec_mux_add_pkg::*;
(
    input  logic [15:0] stim_i,
    output logic [3:0]  decout_o,
    output logic [1:0]  muxout_o,
    output logic        s_o,
    output logic        co_o
);

    logic [1:0] sel1, sel2;
    logic       en, x, y, ci;

    assign sel1 = stim_i[SEL1_LSB +: FIELD_W];
    assign sel2 = stim_i[SEL2_LSB +: FIELD_W];
    assign en   = stim_i[EN_BIT];
    assign x    = stim_i[X_BIT];
    assign y    = stim_i[Y_BIT];
    assign ci   = stim_i[CI_BIT];

    always_comb begin
        decout_o = en ? (4'b0001 << sel1) : 4'b0000;
        unique case (sel2)
            2'd0:    muxout_o = stim_i[A_LSB +: FIELD_W];
            2'd1:    muxout_o = stim_i[B_LSB +: FIELD_W];
            2'd2:    muxout_o = stim_i[C_LSB +: FIELD_W];
            default: muxout_o = stim_i[D_LSB +: FIELD_W];
        endcase
        s_o  = x ^ y ^ ci;
        co_o = (x & y) | (x & ci) | (y & ci);
    end

endmodule

// File: rtl/dec_mux_add_checker.sv
// Run-based response checker: compares observed decout/muxout/S/Co against
// the golden model, counts mismatches, records the first one, builds a MISR.
module dec_mux_add_checker
    import dec_mux_add_pkg::*;
#(
    parameter int unsigned VEC_COUNT = 65536,
    parameter logic [15:0] MISR_POLY = 16'hB400
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] stim,
    input  logic [3:0]  decout,
    input  logic [1:0]  muxout,
    input  logic        S,
    input  logic        Co,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [16:0] err_count,
    output logic [15:0] first_err_idx,
    output logic        first_err_valid,
    output logic [15:0] signature
);

    localparam logic [15:0] LAST_IDX = 16'(VEC_COUNT - 1);

    state_e      state_q;
    logic [15:0] idx_q;

    logic        acc_q, mis_q;
    logic [15:0] acc_idx_q;
    logic [7:0]  resp_q;

    logic [16:0] err_q, err_d;
    logic [15:0] fidx_q, fidx_d;
    logic        fvalid_q, fvalid_d;
    logic [15:0] sig_q, sig_d;

    logic [3:0]  exp_dec;
    logic [1:0]  exp_mux;
    logic        exp_s, exp_co;
    logic [7:0]  obs_resp, exp_resp;
    logic        accept, start_ok;

    dec_mux_add_model u_model (
        .stim_i   (stim),
        .decout_o (exp_dec),
        .muxout_o (exp_mux),
        .s_o      (exp_s),
        .co_o     (exp_co)
    );

    assign obs_resp = {Co, S, muxout, decout};
    assign exp_resp = {exp_co, exp_s, exp_mux, exp_dec};
    assign accept   = in_valid && (state_q == ST_RUN);
    assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q <= ST_RUN;
                        idx_q   <= '0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        idx_q <= idx_q + 16'd1;
                        if (idx_q == LAST_IDX) state_q <= ST_DRAIN;
                    end
                end
                default: state_q <= ST_DONE;
            endcase
        end
    end

    // Comparison is captured at acceptance; DRAIN lets the last beat land.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q     <= 1'b0;
            mis_q     <= 1'b0;
            acc_idx_q <= '0;
            resp_q    <= '0;
        end else begin
            acc_q     <= accept;
            mis_q     <= accept && (obs_resp != exp_resp);
            acc_idx_q <= idx_q;
            resp_q    <= obs_resp;
        end
    end

    always_comb begin
        err_d    = err_q;
        fidx_d   = fidx_q;
        fvalid_d = fvalid_q;
        sig_d    = sig_q;
        if (start_ok) begin
            err_d    = '0;
            fidx_d   = '0;
            fvalid_d = 1'b0;
            sig_d    = MISR_SEED;
        end else if (acc_q) begin
            sig_d = misr_next(sig_q, resp_q, MISR_POLY);
            if (mis_q) begin
                if (err_q != '1) err_d = err_q + 17'd1;
                if (!fvalid_q) begin
                    fidx_d   = acc_idx_q;
                    fvalid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= '0;
            fidx_q   <= '0;
            fvalid_q <= 1'b0;
            sig_q    <= MISR_SEED;
        end else begin
            err_q    <= err_d;
            fidx_q   <= fidx_d;
            fvalid_q <= fvalid_d;
            sig_q    <= sig_d;
        end
    end

    assign in_ready        = (state_q == ST_RUN);
    assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (err_q == '0);
    assign err_count       = err_q;
    assign first_err_idx   = fidx_q;
    assign first_err_valid = fvalid_q;
    assign signature       = sig_q;

endmodule
